// File: rtl/muldiv_sched_if.sv
// muldiv_sched_if: EX-side command/read handshake plus the Multiplier HI/LO unit connection.
interface muldiv_sched_if;
   logic        req_valid;
   logic [2:0]  req_ctrl;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        req_ready;
   logic        flush;
   logic        rd_req;
   logic        rd_sel;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        md_start;
   logic [2:0]  md_ctrl;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_busy;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic        err_timeout;
   modport slave (
      input  req_valid, req_ctrl, req_a, req_b, flush, rd_req, rd_sel, md_busy, md_hi, md_lo,
      output req_ready, rd_ready, rd_valid, rd_data, md_start, md_ctrl, md_a, md_b, err_timeout
   );
   modport master (
      output req_valid, req_ctrl, req_a, req_b, flush, rd_req, rd_sel, md_busy, md_hi, md_lo,
      input  req_ready, rd_ready, rd_valid, rd_data, md_start, md_ctrl, md_a, md_b, err_timeout
   );
endinterface

// File: rtl/muldiv_sched.sv
// muldiv_sched: buffers one mult/div/mthi/mtlo command, issues it only when the HI/LO unit is idle,
// and serves mfhi/mflo reads after all older commands have retired.
module muldiv_sched #(
   parameter int TIMEOUT = 31,
   parameter int CNT_W   = 6
) (
   input logic           clk,
   input logic           reset,
   muldiv_sched_if.slave bus
);
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] RUN     = 1'b1;
   localparam logic [2:0] MT_MUL  = 3'd1;
   localparam logic [2:0] MT_DIVU = 3'd4;
   logic [0:0]       state_q, state_d;
   logic             pend_valid_q, pend_valid_d;
   logic [2:0]       pend_ctrl_q;
   logic [31:0]      pend_a_q, pend_b_q;
   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             rd_valid_q;
   logic [31:0]      rd_data_q;
   logic             err_q, err_d;
   logic             accept, issue, rd_acc, is_long;
   assign bus.req_ready   = !pend_valid_q && !bus.flush;
   assign accept          = bus.req_valid && bus.req_ready;
   assign issue           = pend_valid_q && state_q == IDLE && !bus.flush;
   assign bus.md_start    = issue;
   assign bus.md_ctrl     = pend_ctrl_q;
   assign bus.md_a        = pend_a_q;
   assign bus.md_b        = pend_b_q;
   // a read waits for both the slot and the unit, and yields to a command presented the same cycle
   assign bus.rd_ready    = state_q == IDLE && !pend_valid_q && !bus.req_valid && !bus.flush;
   assign rd_acc          = bus.rd_req && bus.rd_ready;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.err_timeout = err_q;
   assign is_long         = pend_ctrl_q >= MT_MUL && pend_ctrl_q <= MT_DIVU;
   assign pend_valid_d    = accept ? 1'b1 : (issue || bus.flush) ? 1'b0 : pend_valid_q;
   always_comb begin
      state_d  = state_q;
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q;
      if (state_q == IDLE) begin
         if (issue && is_long) begin
            state_d  = RUN;
            wd_cnt_d = '0;
         end
      end else if (!bus.md_busy) begin
         state_d = IDLE;
      end else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end else begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pend_valid_q <= 1'b0;
         pend_ctrl_q  <= '0;
         pend_a_q     <= '0;
         pend_b_q     <= '0;
         wd_cnt_q     <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         wd_cnt_q     <= wd_cnt_d;
         err_q        <= err_d;
         rd_valid_q   <= rd_acc;
         if (accept) begin
            pend_ctrl_q <= bus.req_ctrl;
            pend_a_q    <= bus.req_a;
            pend_b_q    <= bus.req_b;
         end
         if (rd_acc) rd_data_q <= bus.rd_sel ? bus.md_hi : bus.md_lo;
      end
   end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed bench with a behavioural HI/LO unit and a read-data scoreboard.
module tb_muldiv_sched;
   localparam logic [2:0] MUL = 3'd1, MULU = 3'd2, DIV = 3'd3, DIVU = 3'd4, SETHI = 3'd5, SETLO = 3'd6;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic force_busy = 1'b0;
   int compared = 0;
   int mismatched = 0;
   int start_cnt = 0;
   logic [31:0] exp_q[$];
   muldiv_sched_if bus();
   muldiv_sched #(.TIMEOUT(31), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic        m_busy;
   logic [3:0]  m_cnt;
   logic [31:0] m_hi, m_lo, r_hi, r_lo;
   assign bus.md_busy = m_busy | force_busy;
   assign bus.md_hi   = m_hi;
   assign bus.md_lo   = m_lo;
   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0; m_cnt <= 4'd0; m_hi <= '0; m_lo <= '0; r_hi <= '0; r_lo <= '0;
      end else if (bus.md_start) begin
         case (bus.md_ctrl)
            SETHI: m_hi <= bus.md_a;
            SETLO: m_lo <= bus.md_a;
            MUL: begin {r_hi, r_lo} <= $signed(bus.md_a) * $signed(bus.md_b); m_busy <= 1'b1; m_cnt <= 4'd5; end
            MULU: begin {r_hi, r_lo} <= {32'd0, bus.md_a} * {32'd0, bus.md_b}; m_busy <= 1'b1; m_cnt <= 4'd5; end
            DIV: begin
               r_lo <= $signed(bus.md_a) / $signed(bus.md_b); r_hi <= $signed(bus.md_a) % $signed(bus.md_b);
               m_busy <= 1'b1; m_cnt <= 4'd10;
            end
            DIVU: begin r_lo <= bus.md_a / bus.md_b; r_hi <= bus.md_a % bus.md_b; m_busy <= 1'b1; m_cnt <= 4'd10; end
            default: ;
         endcase
      end else if (m_busy) begin
         if (m_cnt == 4'd1) begin m_busy <= 1'b0; m_hi <= r_hi; m_lo <= r_lo; end
         else m_cnt <= m_cnt - 4'd1;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.md_start && !force_busy) begin
         start_cnt++;
         chk("start_while_busy", 32'(bus.md_busy), 32'd0);
      end
      if (bus.rd_ready && !force_busy) chk("rd_ready_while_busy", 32'(bus.md_busy), 32'd0);
      if (bus.rd_valid) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 32'(exp_q.size()), 32'd1);
         else chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
   end
   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      bus.req_valid = 1'b1; bus.req_ctrl = c; bus.req_a = a; bus.req_b = b;
      @(negedge clk);
      while (!bus.req_ready && n < 100) begin n++; @(negedge clk); end
      chk("send_accept", 32'(n < 100), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask
   task automatic rd(input logic sel, input logic [31:0] exp, output int waited);
      exp_q.push_back(exp);
      bus.rd_req = 1'b1; bus.rd_sel = sel; waited = 0;
      @(negedge clk);
      while (!bus.rd_ready && waited < 100) begin waited++; @(negedge clk); end
      chk("rd_accept", 32'(waited < 100), 32'd1);
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
   endtask
   initial begin
      int w, n, s0;
      bus.req_valid = 0; bus.req_ctrl = 0; bus.req_a = 0; bus.req_b = 0;
      bus.flush = 0; bus.rd_req = 0; bus.rd_sel = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_md_start", 32'(bus.md_start), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rd_ready", 32'(bus.rd_ready), 32'd1);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data", bus.rd_data, 32'd0);
      chk("rst_err", 32'(bus.err_timeout), 32'd0);
      // signed multiply, start the cycle after accept, reads held off until idle
      send(MUL, 32'hFFFF_FFFD, 32'd7);
      chk("mul_start", 32'(bus.md_start), 32'd1);
      chk("mul_ctrl", 32'(bus.md_ctrl), 32'(MUL));
      chk("mul_a", bus.md_a, 32'hFFFF_FFFD);
      rd(1'b1, 32'hFFFF_FFFF, w);
      chk("mul_rd_held", 32'(w >= 6), 32'd1);
      rd(1'b0, 32'hFFFF_FFEB, w);
      chk("mul_rd_lo_wait", 32'(w), 32'd0);
      // back-to-back divu: second waits in the slot until the unit is idle
      send(DIVU, 32'd100, 32'd7);
      send(DIVU, 32'd9, 32'd2);
      chk("divu2_pending_no_start", 32'(bus.md_start), 32'd0);
      rd(1'b0, 32'd4, w);
      rd(1'b1, 32'd1, w);
      // mthi followed immediately by mfhi
      send(SETHI, 32'h0000_1234, 32'd0);
      rd(1'b1, 32'h0000_1234, w);
      chk("mthi_rd_held", 32'(w >= 1), 32'd1);
      // flush drops an unissued div
      s0 = start_cnt;
      send(DIV, 32'd50, 32'd3);
      bus.flush = 1'b1;
      #1;
      chk("flush_no_start", 32'(bus.md_start), 32'd0);
      chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      #1;
      chk("postflush_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (12) @(posedge clk);
      #1;
      chk("flush_start_cnt", 32'(start_cnt), 32'(s0));
      rd(1'b1, 32'h0000_1234, w);
      rd(1'b0, 32'd4, w);
      @(posedge clk); #1;
      // reset in the middle of a multiply
      send(MUL, 32'd6, 32'd7);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rstrun_rd_ready", 32'(bus.rd_ready), 32'd1);
      chk("rstrun_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rstrun_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rstrun_md_start", 32'(bus.md_start), 32'd0);
      // busy stuck high: watchdog fires after 31 RUN cycles
      send(MUL, 32'd2, 32'd3);
      force_busy = 1'b1;
      n = 0;
      while (!bus.err_timeout && n < 60) begin @(posedge clk); #1; n++; end
      chk("wd_edges_to_err", 32'(n), 32'd32);
      chk("wd_fsm_idle", 32'(bus.rd_ready), 32'd1);
      repeat (8) @(posedge clk);
      #1;
      chk("wd_sticky_forced", 32'(bus.err_timeout), 32'd1);
      force_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("wd_sticky_released", 32'(bus.err_timeout), 32'd1);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
